alu_cmd_issuer: RTL and testbench

Hardware initiator for the ALU operand/opcode interface, the synthesizable counterpart to a bench that drives ALU ports directly. It accepts ALU commands on a valid/ready channel and buffers them in a small FIFO. It drives one command at a time onto the ALU's operandA/operandB/aluOp inputs and captures result/zeroFlag/carryOut one cycle later. Captured results go out on a valid/ready response channel. It sits between the control/decode logic and the combinational ALU.

---
 rtl/alu_cmd_issuer.sv | 192 +++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, drives them one at a time into a combinational ALU, returns results in order (stats counters under ALU_CMD_STATS_EN).
// Latency: command accepted at edge E0 with an idle FSM gives rspValid after E2; steady state is one response per 2 cycles.
// Backpressure: cmdReady drops while the FIFO is full; a stalled response holds every rsp output stable.

module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushEn,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popEn,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full     = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty    = (wrPtr == rdPtr);
  assign headData = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (pushEn && !full) begin
      mem[wrPtr[AW-1:0]] <= pushData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushEn && !full) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (popEn && !empty) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end
endmodule

module alu_cmd_issuer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  input  logic [3:0]       cmdOp,
  output logic [WIDTH-1:0] operandA,
  output logic [WIDTH-1:0] operandB,
  output logic [3:0]       aluOp,
  input  logic [WIDTH-1:0] result,
  input  logic             zeroFlag,
  input  logic             carryOut,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspResult,
  output logic             rspZero,
  output logic             rspCarry,
  output logic [3:0]       rspOp,
  output logic             rspIllegal
`ifdef ALU_CMD_STATS_EN
  ,
  output logic [15:0]      statDone,
  output logic [7:0]       statIllegal
`endif
);
  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  localparam int CW = $bits(cmd_t);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state;
  cmd_t            cmdIn;
  cmd_t            headCmd;
  logic [CW-1:0]   headBits;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            cmdPush;
  logic            rspFire;
  logic            popEn;

  assign cmdReady = !fifoFull && !rst;
  assign cmdPush  = cmdValid && cmdReady;
  assign cmdIn    = '{op: cmdOp, b: cmdB, a: cmdA};
  assign headCmd  = headBits;
  assign rspFire  = rspValid && rspReady;
  // A pop happens from IDLE, or in the same edge as a response handshake.
  assign popEn    = !fifoEmpty && ((state == IDLE) || ((state == RESP) && rspFire));

  alu_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .pushEn   (cmdPush),
    .pushData (cmdIn),
    .popEn    (popEn),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .headData (headBits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      operandA   <= '0;
      operandB   <= '0;
      aluOp      <= '0;
      rspValid   <= 1'b0;
      rspResult  <= '0;
      rspZero    <= 1'b0;
      rspCarry   <= 1'b0;
      rspOp      <= '0;
      rspIllegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (popEn) begin
            operandA <= headCmd.a;
            operandB <= headCmd.b;
            aluOp    <= headCmd.op;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // aluOp still holds the issued opcode, so it doubles as the op/illegal latch.
          rspValid   <= 1'b1;
          rspOp      <= aluOp;
          rspIllegal <= aluOp[3];
          if (aluOp[3]) begin
            rspResult <= '0;
            rspZero   <= 1'b0;
            rspCarry  <= 1'b0;
          end else begin
            rspResult <= result;
            rspZero   <= zeroFlag;
            rspCarry  <= carryOut;
          end
          state <= RESP;
        end
        RESP: begin
          if (rspFire) begin
            rspValid <= 1'b0;
            if (popEn) begin
              operandA <= headCmd.a;
              operandB <= headCmd.b;
              aluOp    <= headCmd.op;
              state    <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_CMD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      statDone    <= '0;
      statIllegal <= '0;
    end else if (rspFire) begin
      statDone <= statDone + 16'd1;
      if (rspIllegal && (statIllegal != 8'hFF)) begin
        statIllegal <= statIllegal + 8'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Randomized self-checking bench for alu_cmd_issuer with a behavioural ALU and an in-order scoreboard.
module tb_alu_cmd_issuer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdA;
  logic [31:0] cmdB;
  logic [3:0]  cmdOp;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [3:0]  aluOp;
  logic [31:0] result;
  logic        zeroFlag;
  logic        carryOut;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspResult;
  logic        rspZero;
  logic        rspCarry;
  logic [3:0]  rspOp;
  logic        rspIllegal;
`ifdef ALU_CMD_STATS_EN
  logic [15:0] statDone;
  logic [7:0]  statIllegal;
`endif

  int total = 0;
  int bad   = 0;
  int rspCount = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        c;
    logic [3:0]  op;
    logic        ill;
  } exp_t;

  exp_t        expQ[$];
  logic        held = 1'b0;
  logic [38:0] heldVal;

  alu_cmd_issuer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdA(cmdA), .cmdB(cmdB), .cmdOp(cmdOp),
    .operandA(operandA), .operandB(operandB), .aluOp(aluOp),
    .result(result), .zeroFlag(zeroFlag), .carryOut(carryOut),
    .rspValid(rspValid), .rspReady(rspReady), .rspResult(rspResult),
    .rspZero(rspZero), .rspCarry(rspCarry), .rspOp(rspOp), .rspIllegal(rspIllegal)
`ifdef ALU_CMD_STATS_EN
    , .statDone(statDone), .statIllegal(statIllegal)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, zero, result}. Illegal opcodes produce junk so masking is observable.
  function automatic logic [33:0] aluFn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    w = '0; r = '0; c = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      default: begin r = a ^ 32'hBAD0_0001; c = 1'b1; end
    endcase
    return {c, (r == 32'h0) || op[3], r};
  endfunction

  always_comb {carryOut, zeroFlag, result} = aluFn(operandA, operandB, aluOp);

  function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t        e;
    logic [33:0] r;
    e.op  = op;
    e.ill = op[3];
    if (op[3]) begin
      e.res = '0; e.z = 1'b0; e.c = 1'b0;
    end else begin
      r = aluFn(a, b, op);
      e.res = r[31:0]; e.z = (r[31:0] == 32'h0); e.c = r[33];
    end
    return e;
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [38:0] obs;
    obs = {rspResult, rspZero, rspCarry, rspOp, rspIllegal};
    if (rst) begin
      expQ.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        total++;
        if (rspValid !== 1'b1 || obs !== heldVal) begin
          bad++;
          $display("FAIL stall_hold: got vld=%b rsp=%h, need vld=1 rsp=%h", rspValid, obs, heldVal);
        end
      end
      if (rspValid && rspReady) begin
        total++;
        rspCount++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got rsp=%h with no command outstanding", obs);
        end else begin
          e = expQ.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL scoreboard: got res=%h z=%b c=%b op=%h ill=%b, need res=%h z=%b c=%b op=%h ill=%b",
                     rspResult, rspZero, rspCarry, rspOp, rspIllegal, e.res, e.z, e.c, e.op, e.ill);
          end
        end
      end
      if (cmdValid && cmdReady) expQ.push_back(refModel(cmdA, cmdB, cmdOp));
      held    = rspValid && !rspReady;
      heldVal = obs;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // All tasks start and end at posedge+1.
  task automatic pushCmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n;
    n = 0;
    cmdValid = 1'b1; cmdA = a; cmdB = b; cmdOp = op;
    @(negedge clk);
    while (!cmdReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmdReady) begin
      total++; bad++;
      $display("FAIL push_timeout: cmdReady=%b after %0d cycles, need 1", cmdReady, n);
    end
    @(posedge clk); #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitRsp(output logic found);
    int n;
    n = 0;
    @(negedge clk);
    while (!rspValid && n < 100) begin
      @(negedge clk);
      n++;
    end
    found = rspValid;
    if (!found) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rspValid=%b after %0d cycles, need 1", rspValid, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({cmdReady, operandA, operandB, aluOp, rspValid, rspResult, rspZero, rspCarry, rspOp, rspIllegal} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b a=%h b=%h op=%h vld=%b res=%h, need all 0",
               cmdReady, operandA, operandB, aluOp, rspValid, rspResult);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cmdReady !== 1'b1) begin bad++; $display("FAIL reset_release_rdy: got %b need 1", cmdReady); end
    @(posedge clk); #1;
  endtask

  task automatic test_add_latency();
    rspReady = 1'b1;
    pushCmd(32'h1, 32'h2, 4'd0);
    @(negedge clk);
    total++;
    if (rspValid !== 1'b0) begin bad++; $display("FAIL lat_e0: rspValid=%b need 0", rspValid); end
    @(posedge clk); @(negedge clk);
    total++;
    if (rspValid !== 1'b0 || operandA !== 32'h1 || operandB !== 32'h2 || aluOp !== 4'd0) begin
      bad++;
      $display("FAIL lat_e1: vld=%b a=%h b=%h op=%h need 0/1/2/0", rspValid, operandA, operandB, aluOp);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (rspValid !== 1'b1 || rspResult !== 32'h3 || rspZero !== 1'b0 || rspOp !== 4'd0) begin
      bad++;
      $display("FAIL lat_e2: vld=%b res=%h z=%b op=%h need 1/3/0/0", rspValid, rspResult, rspZero, rspOp);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (rspValid !== 1'b0) begin bad++; $display("FAIL lat_clear: rspValid=%b need 0", rspValid); end
    @(posedge clk); #1;
  endtask

  task automatic test_carry_zero();
    logic f;
    rspReady = 1'b1;
    pushCmd(32'hFFFF_FFFF, 32'h1, 4'd0);
    waitRsp(f);
    total++;
    if (rspResult !== 32'h0 || rspZero !== 1'b1 || rspCarry !== 1'b1) begin
      bad++;
      $display("FAIL add_carry: res=%h z=%b c=%b need 0/1/1", rspResult, rspZero, rspCarry);
    end
    @(posedge clk); #1;
    pushCmd(32'h4, 32'h2, 4'd1);
    waitRsp(f);
    total++;
    if (rspResult !== 32'h2 || rspZero !== 1'b0) begin
      bad++;
      $display("FAIL sub: res=%h z=%b need 2/0", rspResult, rspZero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    logic [3:0]  to[6];
    logic [31:0] want[6];
    logic [31:0] got[6];
    int          tcyc[6];
    int          idx, acc, n, cyc;
    ta   = '{32'h00FF, 32'h00FF, 32'h00FF, 32'h00FF, 32'h00FF, 32'h8000_0000};
    tb   = '{32'hFF00, 32'hFF00, 32'hFF00, 32'h0, 32'h4, 32'h4};
    to   = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    want = '{32'h0, 32'hFFFF, 32'hFFFF, 32'hFFFF_FF00, 32'h0000_0FF0, 32'hF800_0000};
    rspReady = 1'b0;
    idx = 0; acc = 0;
    cmdValid = 1'b1; cmdA = ta[0]; cmdB = tb[0]; cmdOp = to[0];
    for (int c = 0; c < 20 && acc < 5; c++) begin
      @(negedge clk);
      if (cmdReady) begin acc++; idx++; end
      @(posedge clk); #1;
      if (idx < 6) begin cmdA = ta[idx]; cmdB = tb[idx]; cmdOp = to[idx]; end
    end
    total++;
    if (acc != 5) begin bad++; $display("FAIL bp_accepts: got %0d need 5", acc); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (cmdReady !== 1'b0 || rspValid !== 1'b1 || rspResult !== 32'h0 || rspOp !== 4'd2) begin
        bad++;
        $display("FAIL bp_stall: rdy=%b vld=%b res=%h op=%h need 0/1/0/2", cmdReady, rspValid, rspResult, rspOp);
      end
      @(posedge clk); #1;
    end
    rspReady = 1'b1;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      if (cmdValid && cmdReady) idx++;
      if (rspValid && rspReady) begin got[n] = rspResult; tcyc[n] = cyc; n++; end
      @(posedge clk); #1;
      if (idx >= 6) cmdValid = 1'b0;
      cyc++;
    end
    cmdValid = 1'b0;
    total++;
    if (n != 6) begin bad++; $display("FAIL bp_count: got %0d responses need 6", n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (got[i] !== want[i]) begin bad++; $display("FAIL bp_order%0d: got %h need %h", i, got[i], want[i]); end
    end
    for (int i = 1; i < n; i++) begin
      total++;
      if (tcyc[i] - tcyc[i-1] != 2) begin
        bad++;
        $display("FAIL bp_throughput%0d: gap %0d need 2", i, tcyc[i] - tcyc[i-1]);
      end
    end
  endtask

  task automatic test_illegal();
    logic f;
    rspReady = 1'b1;
    pushCmd(32'h5, 32'h7, 4'b1000);
    waitRsp(f);
    total++;
    if (rspIllegal !== 1'b1 || rspResult !== 32'h0 || rspZero !== 1'b0 || rspCarry !== 1'b0 ||
        rspOp !== 4'b1000 || aluOp !== 4'b1000) begin
      bad++;
      $display("FAIL illegal: ill=%b res=%h z=%b c=%b op=%h aluOp=%h need 1/0/0/0/8/8",
               rspIllegal, rspResult, rspZero, rspCarry, rspOp, aluOp);
    end
    @(posedge clk); #1;
    pushCmd(32'd10, 32'd20, 4'd0);
    waitRsp(f);
    total++;
    if (rspIllegal !== 1'b0 || rspResult !== 32'd30) begin
      bad++;
      $display("FAIL after_illegal: ill=%b res=%h need 0/1e", rspIllegal, rspResult);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic saw;
    logic f;
    rspReady = 1'b0;
    pushCmd(32'h11, 32'h1, 4'd0);
    pushCmd(32'h22, 32'h1, 4'd0);
    pushCmd(32'h33, 32'h1, 4'd0);
    pushCmd(32'h44, 32'h1, 4'd0);
    rspReady = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    rspReady = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cmdReady !== 1'b0 || rspValid !== 1'b0 || operandA !== 32'h22) begin
      bad++;
      $display("FAIL rstmid_pre: rdy=%b vld=%b a=%h need 0/0/22", cmdReady, rspValid, operandA);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({cmdReady, operandA, operandB, aluOp, rspValid, rspResult, rspZero, rspCarry, rspOp, rspIllegal} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: rdy=%b a=%h b=%h op=%h vld=%b res=%h need all 0",
               cmdReady, operandA, operandB, aluOp, rspValid, rspResult);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rspReady = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rspValid) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) begin bad++; $display("FAIL rstmid_ghost: saw rspValid=%b need 0", saw); end
    @(posedge clk); #1;
    pushCmd(32'hF0F0, 32'h0FF0, 4'd4);
    waitRsp(f);
    total++;
    if (rspResult !== 32'hFF00) begin bad++; $display("FAIL rstmid_next: res=%h need ff00", rspResult); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic        done;
    int          startCount;
    int          n;
    logic [3:0]  op;
    done = 1'b0;
    startCount = rspCount;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 9) > 7) op = {1'b1, 3'($urandom_range(0, 7))};
          else op = 4'($urandom_range(0, 7));
          pushCmd($urandom, $urandom, op);
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          rspReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rspReady = 1'b1;
    n = 0;
    @(negedge clk);
    while (expQ.size() != 0 && n < 200) begin @(negedge clk); n++; end
    total++;
    if (expQ.size() != 0 || rspCount - startCount != 40) begin
      bad++;
      $display("FAIL random_drain: pending=%0d responses=%0d need 0/40", expQ.size(), rspCount - startCount);
    end
    @(posedge clk); #1;
  endtask

`ifdef ALU_CMD_STATS_EN
  task automatic test_stats();
    int n;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rspReady = 1'b1;
    pushCmd(32'h1, 32'h1, 4'd0);
    pushCmd(32'h1, 32'h1, 4'b1001);
    pushCmd(32'h3, 32'h1, 4'd1);
    pushCmd(32'h1, 32'h1, 4'b1111);
    pushCmd(32'h6, 32'h3, 4'd2);
    n = 0;
    @(negedge clk);
    while (expQ.size() != 0 && n < 100) begin @(negedge clk); n++; end
    total++;
    if (statDone !== 16'd5 || statIllegal !== 8'd2) begin
      bad++;
      $display("FAIL stats: done=%0d illegal=%0d need 5/2", statDone, statIllegal);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1; cmdValid = 1'b0; cmdA = '0; cmdB = '0; cmdOp = '0; rspReady = 1'b0;
    test_reset();
    test_add_latency();
    test_carry_zero();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
`ifdef ALU_CMD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
